program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//   Loads a program into the 16-byte RAM from an external byte stream, with a valid/ready handshake.
//   While loading, it holds the CPU cleared and takes ownership of the RAM write path from the control unit.
//   Top level: o_BUS_GRANT_LOADER muxes RAM addr/data/write-enable to the loader and forces ControlUnit signals to 0.
//   o_CPU_HOLD is ORed into the CPU clear (CPU clear_n = ~o_CPU_HOLD & existing clear_n).
// PARAMETERS
//   DATA_WIDTH   8    width of a RAM word / stream byte
//   ADDR_WIDTH   4    RAM address width
//   RAM_DEPTH    16   number of RAM words; legal load lengths are 0..RAM_DEPTH
// PORTS
//   i_CLOCK_n          in   1             clock; all state updates on its rising edge
//   i_RESET            in   1             asynchronous reset, active-high
//   i_LOAD_START       in   1             start request; sampled only in IDLE
//   i_LOAD_LEN         in   ADDR_WIDTH+1  byte count, sampled with i_LOAD_START
//   i_ABORT            in   1             cancel an active load
//   i_BYTE_VALID       in   1             stream byte present
//   i_BYTE_DATA        in   DATA_WIDTH    stream byte
//   o_BYTE_READY       out  1             loader accepts a byte this cycle
//   o_RAM_ADDR         out  ADDR_WIDTH    RAM write address
//   o_RAM_DATA         out  DATA_WIDTH    RAM write data
//   o_RAM_WE           out  1             RAM write strobe, one cycle per byte
//   o_BUS_GRANT_LOADER out  1             loader owns the RAM/bus; CPU control signals are gated off
//   o_CPU_HOLD         out  1             hold the CPU (PC, T-cycle, registers) cleared
//   o_BUSY             out  1             state != IDLE
//   o_DONE             out  1             one-cycle pulse on successful completion
//   o_ERROR            out  1             sticky; set on bad length or abort
// BEHAVIOUR
//   Reset (asynchronous):
//     - state = IDLE; byte count and address = 0; all outputs = 0.
//     - A reset mid-load abandons the load immediately. RAM keeps any bytes already written.
//   All outputs are registered or decoded from state only.
//   States:
//     - IDLE: CPU runs. On i_LOAD_START:
//       - len > RAM_DEPTH: set o_ERROR and stay in IDLE.
//       - otherwise: latch len, clear o_ERROR, address = 0, go to HOLD.
//     - HOLD: o_CPU_HOLD = 1, grant = 0. One quiesce cycle, so any in-flight CPU RAM write completes.
//       Next state is WAIT_BYTE, or RELEASE if len == 0.
//     - WAIT_BYTE: hold = 1, grant = 1, o_BYTE_READY = 1.
//       On i_BYTE_VALID & o_BYTE_READY: latch the data into o_RAM_DATA and go to WRITE.
//     - WRITE: o_RAM_WE = 1 with o_RAM_ADDR and o_RAM_DATA stable; o_BYTE_READY = 0.
//       On exit, address and count increment. Next state is RELEASE if the new count == len, else WAIT_BYTE.
//     - RELEASE: grant = 0, hold = 1 for one cycle, then IDLE.
//       o_DONE pulses in the first IDLE cycle, unless the load was aborted.
//   Address rule:
//     - The address runs 0..len-1 and never wraps. For len == RAM_DEPTH, the last write is at address RAM_DEPTH-1.
//     - The counter is ADDR_WIDTH+1 bits wide, so count == 16 is representable.
//   Throughput: at most 1 byte per 2 cycles.
//   Timing from i_LOAD_START sampled at edge k:
//     - o_CPU_HOLD rises after edge k.
//     - o_BYTE_READY rises after edge k+1.
//   Abort:
//     - i_ABORT in HOLD, WAIT_BYTE or WRITE goes to RELEASE and sets o_ERROR.
//     - An abort in WRITE still completes that cycle's write. No o_DONE pulse.
//   Simultaneous events:
//     - i_ABORT together with a byte handshake: abort wins; the byte is not accepted.
//     - i_LOAD_START outside IDLE is ignored.
//     - i_BYTE_VALID outside WAIT_BYTE is not accepted. The source must hold the byte until ready.
//   Invariants:
//     - o_BUS_GRANT_LOADER is only ever asserted while o_CPU_HOLD is also asserted.
//     - o_RAM_WE is only asserted in WRITE.
// TESTING
//   1. Normal load: LEN=3, bytes 0x14,0x2F,0xE0 sent back-to-back
//      -> writes (0,0x14),(1,0x2F),(2,0xE0); o_DONE pulses once; hold spans HOLD..RELEASE.
//   2. Full RAM: LEN=16, bytes 0x00..0x0F with random VALID gaps
//      -> 16 writes at addresses 0..15 with no wrap; DONE pulses; exactly 16 handshakes.
//   3. Edge lengths: LEN=0 -> HOLD, RELEASE, DONE with no o_RAM_WE.
//      LEN=17 -> o_ERROR=1, o_BUSY stays 0.
//   4. Abort: LEN=8, assert i_ABORT after byte 3 is accepted
//      -> at most 3 writes, o_ERROR=1, no DONE, grant and hold drop within 2 cycles.
//   5. Async reset while in WRITE of byte 2
//      -> all outputs 0 without waiting for a clock edge; a new START with LEN=1 then completes normally.
//   6. START while BUSY and VALID held outside WAIT_BYTE
//      -> START ignored, no extra writes, byte accepted only when o_BYTE_READY=1.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: streams bytes into the 16-word RAM over a valid/ready handshake
// while holding the CPU cleared and owning the RAM write path.
module program_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 16
) (
  input  logic                  i_CLOCK_n,
  input  logic                  i_RESET,
  input  logic                  i_LOAD_START,
  input  logic [ADDR_WIDTH:0]   i_LOAD_LEN,
  input  logic                  i_ABORT,
  input  logic                  i_BYTE_VALID,
  input  logic [DATA_WIDTH-1:0] i_BYTE_DATA,
  output logic                  o_BYTE_READY,
  output logic [ADDR_WIDTH-1:0] o_RAM_ADDR,
  output logic [DATA_WIDTH-1:0] o_RAM_DATA,
  output logic                  o_RAM_WE,
  output logic                  o_BUS_GRANT_LOADER,
  output logic                  o_CPU_HOLD,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_ERROR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT_BYTE,
    S_WRITE,
    S_RELEASE
  } state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_inc;
  logic                  aborted_q;
  logic                  len_bad;
  logic                  abortable;

  assign count_inc = count_q + CNT_ONE;
  assign len_bad   = (i_LOAD_LEN > DEPTH_L);
  assign abortable = (state == S_HOLD) || (state == S_WAIT_BYTE) || (state == S_WRITE);

  always_ff @(posedge i_CLOCK_n or posedge i_RESET) begin
    if (i_RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort takes priority over both the byte handshake and the write-done decision.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_LOAD_START && !len_bad) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (i_ABORT || (len_q == '0)) state_nxt = S_RELEASE;
        else                          state_nxt = S_WAIT_BYTE;
      end
      S_WAIT_BYTE: begin
        if (i_ABORT)           state_nxt = S_RELEASE;
        else if (i_BYTE_VALID) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (i_ABORT || (count_inc == len_q)) state_nxt = S_RELEASE;
        else                                 state_nxt = S_WAIT_BYTE;
      end
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign o_CPU_HOLD         = (state != S_IDLE);
  assign o_BUSY             = (state != S_IDLE);
  assign o_BUS_GRANT_LOADER = (state == S_WAIT_BYTE) || (state == S_WRITE);
  assign o_BYTE_READY       = (state == S_WAIT_BYTE);
  assign o_RAM_WE           = (state == S_WRITE);

  always_ff @(posedge i_CLOCK_n or posedge i_RESET) begin
    if (i_RESET) begin
      len_q      <= '0;
      count_q    <= '0;
      aborted_q  <= 1'b0;
      o_RAM_ADDR <= '0;
      o_RAM_DATA <= '0;
      o_DONE     <= 1'b0;
      o_ERROR    <= 1'b0;
    end else begin
      o_DONE <= (state == S_RELEASE) && !aborted_q;

      if ((state == S_IDLE) && i_LOAD_START) begin
        if (len_bad) begin
          o_ERROR <= 1'b1;
        end else begin
          len_q      <= i_LOAD_LEN;
          count_q    <= '0;
          o_RAM_ADDR <= '0;
          aborted_q  <= 1'b0;
          o_ERROR    <= 1'b0;
        end
      end

      if ((state == S_WAIT_BYTE) && i_BYTE_VALID && !i_ABORT) begin
        o_RAM_DATA <= i_BYTE_DATA;
      end

      // The address stops at the last written word so a full-depth load never wraps to 0.
      if (state == S_WRITE) begin
        count_q <= count_inc;
        if (count_inc != len_q) o_RAM_ADDR <= o_RAM_ADDR + ADDR_ONE;
      end

      if (abortable && i_ABORT) begin
        aborted_q <= 1'b1;
        o_ERROR   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected RAM writes and DONE pulses are queued
// from the load parameters and checked by a monitor as the DUT produces them.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] len;
  logic       abort;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       grant;
  logic       hold;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  logic [11:0] exp_wr[$];
  bit          exp_done[$];

  always #5 clk = ~clk;

  program_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_DEPTH(16)) dut (
    .i_CLOCK_n(clk),
    .i_RESET(rst),
    .i_LOAD_START(start),
    .i_LOAD_LEN(len),
    .i_ABORT(abort),
    .i_BYTE_VALID(valid),
    .i_BYTE_DATA(data),
    .o_BYTE_READY(ready),
    .o_RAM_ADDR(ram_addr),
    .o_RAM_DATA(ram_data),
    .o_RAM_WE(ram_we),
    .o_BUS_GRANT_LOADER(grant),
    .o_CPU_HOLD(hold),
    .o_BUSY(busy),
    .o_DONE(done),
    .o_ERROR(error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic monitor();
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ram_we) begin
          if (exp_wr.size() == 0) begin
            fail($sformatf("unexpected_write addr=%0h data=%0h", ram_addr, ram_data));
          end else begin
            e = exp_wr.pop_front();
            chk("ram_write", {20'd0, ram_addr, ram_data}, {20'd0, e});
          end
        end
        if (done) begin
          if (exp_done.size() == 0) fail("unexpected_done");
          else begin
            void'(exp_done.pop_front());
            checks++;
          end
        end
        if (grant) chk("grant_implies_hold", {31'd0, hold}, 32'd1);
        if (ready && valid && !abort) hs_cnt++;
      end
    end
  endtask

  // Reference model: a load of n accepted bytes writes b[i] at address i for i < n.
  task automatic expect_load(input int n, input logic [7:0] b[16], input bit with_done);
    for (int i = 0; i < n; i++) exp_wr.push_back({i[3:0], b[i]});
    if (with_done) exp_done.push_back(1'b1);
  endtask

  task automatic do_start(input logic [4:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        return;
      end
    end
    fail("ready_timeout");
  endtask

  task automatic send_byte(input logic [7:0] d, input int max_gap);
    bit ok;
    repeat ($urandom_range(0, max_gap)) begin
      @(posedge clk); #1;
    end
    valid = 1'b1;
    data  = d;
    wait_ready(ok);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    fail("idle_timeout");
  endtask

  task automatic drain();
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
  endtask

  task automatic run_load(input int l, input int max_gap);
    logic [7:0] b[16];
    int hs0;
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    expect_load(l, b, 1'b1);
    hs0 = hs_cnt;
    do_start(5'(l));
    chk("load_error_cleared", {31'd0, error}, 32'd0);
    for (int i = 0; i < l; i++) send_byte(b[i], max_gap);
    wait_idle();
    drain();
    chk("handshake_count", hs_cnt - hs0, l);
  endtask

  initial begin
    logic [7:0] b[16];
    bit ok;
    int hs0;
    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; valid = 1'b0; data = '0;
    fork
      monitor();
    join_none
    #12;
    chk("reset_outputs", {12'd0, ready, ram_addr, ram_data, ram_we, grant, hold, busy, done, error}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Normal load of three back-to-back bytes
    b[0] = 8'h14; b[1] = 8'h2F; b[2] = 8'hE0;
    expect_load(3, b, 1'b1);
    do_start(5'd3);
    chk("hold_after_start", {29'd0, hold, ready, grant}, {29'd0, 3'b100});
    @(posedge clk); #1;
    chk("ready_after_k1", {30'd0, ready, grant}, 32'd3);
    for (int i = 0; i < 3; i++) send_byte(b[i], 0);
    chk("hold_in_load", {31'd0, hold}, 32'd1);
    wait_idle();
    drain();

    // Full RAM with gaps
    for (int i = 0; i < 16; i++) b[i] = 8'(i);
    expect_load(16, b, 1'b1);
    hs0 = hs_cnt;
    do_start(5'd16);
    for (int i = 0; i < 16; i++) send_byte(b[i], 3);
    wait_idle();
    drain();
    chk("full_handshakes", hs_cnt - hs0, 16);
    chk("full_last_addr", {28'd0, ram_addr}, 32'd15);

    // Zero length
    exp_done.push_back(1'b1);
    do_start(5'd0);
    chk("len0_hold", {29'd0, hold, grant, ready}, {29'd0, 3'b100});
    @(posedge clk); #1;
    chk("len0_release", {29'd0, hold, grant, busy}, {29'd0, 3'b101});
    @(posedge clk); #1;
    chk("len0_done", {30'd0, done, busy}, {30'd0, 2'b10});
    drain();

    // Oversized length
    do_start(5'd17);
    chk("len17_error", {29'd0, error, busy, hold}, {29'd0, 3'b100});
    @(posedge clk); #1;
    chk("len17_idle", {30'd0, busy, error}, 32'd1);
    drain();

    // Abort after the third accepted byte
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    expect_load(3, b, 1'b0);
    do_start(5'd8);
    chk("abort_error_cleared", {31'd0, error}, 32'd0);
    for (int i = 0; i < 3; i++) send_byte(b[i], 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_release", {29'd0, grant, hold, error}, {29'd0, 3'b011});
    @(posedge clk); #1;
    chk("abort_dropped", {29'd0, grant, hold, busy}, 32'd0);
    drain();
    chk("abort_error_sticky", {31'd0, error}, 32'd1);

    // Asynchronous reset during the second write
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    expect_load(1, b, 1'b0);
    do_start(5'd4);
    send_byte(b[0], 0);
    send_byte(b[1], 0);
    chk("in_write_before_reset", {31'd0, ram_we}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {12'd0, ready, ram_addr, ram_data, ram_we, grant, hold, busy, done, error}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_load(1, 0);

    // START and VALID held while busy
    b[0] = 8'hA5; b[1] = 8'h3C;
    expect_load(2, b, 1'b1);
    hs0 = hs_cnt;
    do_start(5'd2);
    start = 1'b1; len = 5'd5; valid = 1'b1; data = 8'hA5;
    wait_ready(ok);
    @(posedge clk); #1;
    data = 8'h3C;
    chk("valid_held_in_write", {30'd0, ready, ram_we}, 32'd1);
    wait_ready(ok);
    @(posedge clk); #1;
    valid = 1'b0; start = 1'b0;
    wait_idle();
    drain();
    chk("held_handshakes", hs_cnt - hs0, 2);

    // Random loads
    for (int t = 0; t < 4; t++) run_load($urandom_range(0, 16), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
